// File: rtl/core_sequencer_pkg.sv
// ============================================================================
// Module  : core_pkg
// Brief   : Opcode field constants, decode classes and FSM state encoding
//           shared by the core sequencer files.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    localparam int OPCODE_W = 16;

    localparam logic [1:0] CLS_LOAD  = 2'b00;
    localparam logic [1:0] CLS_ALU2  = 2'b01;
    localparam logic [1:0] CLS_ALU1  = 2'b10;
    localparam logic [1:0] CLS_MISC  = 2'b11;
    localparam logic [1:0] ALU1_SQRT = 2'b11;

    localparam int BIT_SQRT_READ = 11;
    localparam int BIT_STORE     = 8;
    localparam int BIT_END       = 7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        OP_NORMAL     = 2'd0,
        OP_SQRT_START = 2'd1,
        OP_SQRT_READ  = 2'd2,
        OP_END        = 2'd3
    } op_class_e;

    // A store-class MISC word (bit 8 set) is never treated as END.
    function automatic op_class_e decode_op(input logic [OPCODE_W-1:0] w);
        op_class_e cls;
        cls = OP_NORMAL;
        if (w[15:14] == CLS_ALU1 && w[13:12] == ALU1_SQRT) begin
            cls = w[BIT_SQRT_READ] ? OP_SQRT_READ : OP_SQRT_START;
        end else if (w[15:14] == CLS_MISC && !w[BIT_STORE] && w[BIT_END]) begin
            cls = OP_END;
        end
        return cls;
    endfunction

endpackage

`default_nettype wire

// File: rtl/core_sequencer_if.sv
// ============================================================================
// Module  : core_sequencer_if
// Brief   : Program-load, control and core broadcast signals of the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface core_sequencer_if #(
    parameter int PROG_DEPTH = 32
) ();
    localparam int AW = $clog2(PROG_DEPTH);

    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [15:0]   prog_data;
    logic          start;
    logic          busy;
    logic          done;
    logic [15:0]   opcode;
    logic          execute;
    logic [AW-1:0] pc;

    modport master (
        output prog_we, prog_addr, prog_data, start,
        input  busy, done, opcode, execute, pc
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, start,
        output busy, done, opcode, execute, pc
    );
endinterface

`default_nettype wire

// File: rtl/core_sequencer_sqrt_interlock.sv
// ============================================================================
// Module  : sqrt_interlock
// Brief   : Down-counter guarding sqrt reads until the sqrt pipe has drained.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sqrt_interlock #(
    parameter int LATENCY = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic ready_o
);
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Reload wins over decrement so back-to-back sqrt starts restart the wait.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = 8'(LATENCY);
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ready_o = (cnt_q == 8'd0);

endmodule

`default_nettype wire

// File: rtl/core_sequencer.sv
// ============================================================================
// Module  : core_sequencer
// Brief   : Instruction store plus lock-step opcode broadcaster with sqrt
//           interlock and END / address-wrap termination.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module core_sequencer
    import core_pkg::*;
#(
    parameter int PROG_DEPTH   = 32,
    parameter int SQRT_LATENCY = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    core_sequencer_if.slave      bus
);
    localparam int            AW      = $clog2(PROG_DEPTH);
    localparam logic [AW-1:0] PC_LAST = AW'(PROG_DEPTH - 1);

    logic [15:0]   mem_q [PROG_DEPTH];

    state_e        state_q,   state_d;
    logic [AW-1:0] pc_q,      pc_d;
    logic [15:0]   opcode_q,  opcode_d;
    logic          execute_q, execute_d;
    logic          busy_q,    busy_d;
    logic          done_q,    done_d;
    logic          wrap_q,    wrap_d;

    logic [15:0]   fetch_w;
    op_class_e     fetch_cls;
    logic          sqrt_load;
    logic          sqrt_ready;
    logic          busy_out;

    assign fetch_w   = mem_q[pc_q];
    assign fetch_cls = decode_op(fetch_w);

    // busy_q drops together with the done pulse; the output covers the done cycle.
    assign busy_out  = busy_q | done_q;

    sqrt_interlock #(
        .LATENCY (SQRT_LATENCY)
    ) u_sqrt_interlock (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (sqrt_load),
        .ready_o (sqrt_ready)
    );

    always_ff @(posedge clk) begin
        if (bus.prog_we && state_q == ST_IDLE && !busy_out) begin
            mem_q[bus.prog_addr] <= bus.prog_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        execute_d = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        wrap_d    = 1'b0;
        sqrt_load = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && !done_q) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                // wrap_q marks that the last store word issued on the previous cycle.
                if (wrap_q || fetch_cls == OP_END) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (fetch_cls == OP_SQRT_READ && !sqrt_ready) begin
                    pc_d = pc_q;
                end else begin
                    opcode_d  = fetch_w;
                    execute_d = 1'b1;
                    pc_d      = pc_q + AW'(1);
                    sqrt_load = (fetch_cls == OP_SQRT_START);
                    wrap_d    = (pc_q == PC_LAST);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            opcode_q  <= 16'h0000;
            execute_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            execute_q <= execute_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wrap_q    <= wrap_d;
        end
    end

    assign bus.busy    = busy_out;
    assign bus.done    = done_q;
    assign bus.opcode  = opcode_q;
    assign bus.execute = execute_q;
    assign bus.pc      = pc_q;

endmodule

`default_nettype wire
